// File: rtl/xor_parity_scheduler.sv
// Round-robin scheduler that time-multiplexes one shared XOR cell among four
// requesters, computing each granted word's XOR-reduction bit-serially.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module xor_parity_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             done_id,
  output logic                   parity
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             acc;
  logic             acc_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic             found;

  // The only XOR in the datapath; every word bit passes through it in turn.
  xor_gate u_xor (
    .a (acc),
    .b (shreg[0]),
    .y (acc_next)
  );

  // Search from ptr upward; two-bit index arithmetic gives the modulo-4 wrap.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      acc     <= 1'b0;
      cnt     <= '0;
      ptr     <= '0;
      win     <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      parity  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            shreg <= data[int'(winner)*WIDTH +: WIDTH];
            acc   <= 1'b0;
            cnt   <= '0;
            win   <= winner;
            grant <= N_REQ'(1) << winner;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          shreg <= shreg >> 1;
          cnt   <= cnt + CNT_W'(1);
          // Last bit: publish the final accumulator value directly.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state   <= DONE;
            done    <= 1'b1;
            parity  <= acc_next;
            done_id <= win;
          end
        end
        DONE: begin
          done  <= 1'b0;
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= win + 2'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xor_parity_scheduler.sv
// Self-checking bench for xor_parity_scheduler: directed vectors, multi-cycle
// corner sequences and a randomized run against a behavioural arbiter model.
module tb_xor_parity_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  grant;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic        parity;

  int checks = 0;
  int errors = 0;

  xor_parity_scheduler #(.N_REQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data    (data),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .parity  (parity)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r;
    logic [7:0] word;
    int         id;
    logic       par;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference parity: count of ones, taken modulo two.
  function automatic logic ref_parity(input logic [7:0] w);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(w[i]);
    return logic'(ones % 2);
  endfunction

  // Reference arbiter: first requester at or after ptr, wrapping around four slots.
  function automatic int ref_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // One full operation, called with the DUT idle; checks every cycle up to the return to IDLE.
  task automatic run_op(input logic [3:0] r, input logic [31:0] d, input int id,
                        input logic par, input bit drop, input string tag);
    logic [3:0] g;
    g = 4'(1 << id);
    req  = r;
    data = d;
    @(posedge clk); #1;
    chk({tag, " grant"}, 32'(grant), 32'(g));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    if (drop) begin
      req  = '0;
      data = '1;
    end
    for (int c = 1; c < 8; c++) begin
      @(posedge clk); #1;
      chk({tag, " early done"}, 32'(done), 32'd0);
    end
    chk({tag, " grant run"}, 32'(grant), 32'(g));
    @(posedge clk); #1;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " parity"}, 32'(parity), 32'(par));
    chk({tag, " done_id"}, 32'(done_id), 32'(id));
    chk({tag, " grant done"}, 32'(grant), 32'(g));
    req = '0;
    @(posedge clk); #1;
    chk({tag, " grant idle"}, 32'(grant), 32'd0);
    chk({tag, " done idle"}, 32'(done), 32'd0);
    chk({tag, " busy idle"}, 32'(busy), 32'd0);
    chk({tag, " parity hold"}, 32'(parity), 32'(par));
    chk({tag, " done_id hold"}, 32'(done_id), 32'(id));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " grant"}, 32'(grant), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " done_id"}, 32'(done_id), 32'd0);
    chk({tag, " parity"}, 32'(parity), 32'd0);
  endtask

  initial begin
    int          m_ptr;
    int          w;
    logic [3:0]  r;
    logic [31:0] d;
    logic [7:0]  wd;
    bit          dr;

    vecs[0] = '{4'b0001, 8'hA5, 0, 1'b0};
    vecs[1] = '{4'b0100, 8'h07, 2, 1'b1};
    vecs[2] = '{4'b0100, 8'hFF, 2, 1'b0};
    vecs[3] = '{4'b0100, 8'h80, 2, 1'b1};

    // Asynchronous reset before any clock edge.
    #2 reset = 1'b1;
    #1 chk_all_zero("reset async");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1 chk_all_zero("reset released");

    // Contention with every request held: order 0,1,2,3,0.
    d = 32'h0F07_0301;
    run_op(4'b1111, d, 0, 1'b1, 1'b0, "rr0");
    run_op(4'b1111, d, 1, 1'b0, 1'b0, "rr1");
    run_op(4'b1111, d, 2, 1'b1, 1'b0, "rr2");
    run_op(4'b1111, d, 3, 1'b0, 1'b0, "rr3");
    run_op(4'b1111, d, 0, 1'b1, 1'b0, "rr4");

    // Request and data change after grant; original word's parity must return.
    run_op(4'b0010, 32'h0000_1300, 1, 1'b1, 1'b1, "drop");

    for (int i = 0; i < 4; i++) begin
      d = {$urandom};
      d[vecs[i].id*8 +: 8] = vecs[i].word;
      run_op(vecs[i].r, d, vecs[i].id, vecs[i].par, 1'b0, $sformatf("vec%0d", i));
    end

    // Reset during RUN: no done, then arbitration restarts from requester 0.
    req  = 4'b0100;
    data = 32'h0007_0000;
    @(posedge clk); #1;
    chk("abort grant", 32'(grant), 32'b0100);
    req = '0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_all_zero("abort reset");
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("abort no done", 32'(done), 32'd0);
    end
    run_op(4'b1010, 32'h0000_0100, 1, 1'b1, 1'b0, "post reset");

    // Randomized operations against the reference model.
    m_ptr = 2;
    for (int n = 0; n < 40; n++) begin
      r  = 4'($urandom_range(1, 15));
      d  = {$urandom};
      dr = 1'($urandom);
      w  = ref_winner(r, m_ptr);
      wd = d[w*8 +: 8];
      run_op(r, d, w, ref_parity(wd), dr, $sformatf("rand%0d", n));
      m_ptr = (w + 1) % 4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
